// File: rtl/data_mem_resp_pkg.sv
// Shared constants, bus widths and FSM encodings for the data-memory responder.
// Imported by the interface, the RAM array and the responder top.
package data_mem_resp_pkg;

  localparam int DataAddrBus = 32;
  localparam int DataBus     = 32;
  localparam int SelBus      = 4;

  localparam logic [DataBus-1:0] ZeroWord     = '0;
  localparam logic               RstEnable    = 1'b1;
  localparam logic               WriteEnable  = 1'b1;
  localparam logic               WriteDisable = 1'b0;
  localparam logic               ChipEnable   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Request fields frozen at capture time and used for the whole access.
  typedef struct packed {
    logic                   we;
    logic [DataAddrBus-1:0] addr;
    logic [SelBus-1:0]      sel;
    logic [DataBus-1:0]     data;
  } req_t;

endpackage

// File: rtl/data_mem_resp_if.sv
// Memory-stage request/response bundle between the pipeline initiator and the responder.
// Signal names keep the responder's port view (_i into it, _o out of it).
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;

  logic                   mem_ce_i;
  logic                   mem_we_i;
  logic [DataAddrBus-1:0] mem_addr_i;
  logic [SelBus-1:0]      mem_sel_i;
  logic [DataBus-1:0]     mem_data_i;
  logic [DataBus-1:0]     mem_data_o;
  logic                   mem_ack_o;
  logic                   mem_err_o;
  logic                   stallreq_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, mem_err_o, stallreq_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, mem_err_o, stallreq_o
  );

endinterface

// File: rtl/data_ram_array.sv
// Synchronous single-port word RAM with per-byte write enables and registered read.
// be_i[3] writes bits [31:24] (big-endian lane order).
module data_ram_array
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [SelBus-1:0]     be_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DataBus-1:0]    wdata_i,
  output logic [DataBus-1:0]    rdata_o
);

  logic [DataBus-1:0] mem_q [2**DEPTH_LOG2];
  logic [DataBus-1:0] rdata_q;

  // NOTE: the array has no reset; clearing a RAM would need a write per word, and contents must survive rst.
  always_ff @(posedge clk) begin
    if (we_i == WriteEnable) begin
      for (int b = 0; b < SelBus; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Memory-stage responder: captures a request, waits WAIT_CYCLES, then acks for one cycle.
// Owns the FSM, wait counter and address checks; storage lives in data_ram_array.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_resp_if.slave  bus
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  req_t               req_q, req_d;
  logic               ack_q, ack_d;

  logic [29:0]        widx;
  logic               addr_err;
  logic               ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DataBus-1:0] ram_rdata;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.mem_ce_i == ChipEnable) begin
          req_d   = '{we: bus.mem_we_i, addr: bus.mem_addr_i,
                      sel: bus.mem_sel_i, data: bus.mem_data_i};
          cnt_d   = WaitLoad;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_ce_i != ChipEnable) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ack_d = (state_d == ST_RESP);
  end

  assign widx     = req_q.addr[31:2];
  assign addr_err = (req_q.addr[1:0] != 2'b00) || ((widx >> DEPTH_LOG2) != 30'd0);

  // In IDLE the RAM reads the live address so the word is ready even with zero wait states.
  assign ram_addr = (state_q == ST_IDLE) ? bus.mem_addr_i[DEPTH_LOG2+1:2]
                                         : widx[DEPTH_LOG2-1:0];

  always_comb begin
    ram_we = WriteDisable;
    if ((state_q == ST_RESP) && (req_q.we == WriteEnable) && !addr_err) ram_we = WriteEnable;
  end

  assign bus.mem_ack_o  = ack_q;
  assign bus.mem_err_o  = ack_q & addr_err;
  assign bus.mem_data_o = (ack_q && !addr_err && (req_q.we != WriteEnable)) ? ram_rdata : ZeroWord;
  assign bus.stallreq_o = bus.mem_ce_i & ~bus.mem_ack_o;

  data_ram_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (req_q.sel),
    .addr_i  (ram_addr),
    .wdata_i (req_q.data),
    .rdata_o (ram_rdata)
  );

endmodule
